// File: rtl/kplic_gateway_pkg.sv
// kplic_gateway_pkg: shared sizing defaults and the per-source gateway
// state encoding used by kplic_gateway and kplic_gateway_cell.
package kplic_gateway_pkg;

    // Default number of interrupt sources and the width of a source ID.
    localparam int KPLIC_INT_NUM    = 32;
    localparam int KPLIC_INT_WIDTH  = 5;

    // Default width of the per-source queued-edge counter.
    localparam int KPLIC_EDGE_CNT_W = 2;

    // Gateway FSM states. The encoding is fixed because the core and the
    // register file decode pending/in-service directly from it.
    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

endpackage

// File: rtl/kplic_gateway_cell.sv
// kplic_gateway_cell: one interrupt source. Optional input synchronizer,
// rising-edge detect, IDLE/PENDING/IN_SERVICE FSM and a saturating
// queued-edge counter.
// Build option: KPLIC_GW_SYNC_EN adds a two-flop synchronizer on src_i.
//
// Strobe semantics: claim_i and completion_i are single-cycle strobes that
// act on the clock edge where they are sampled high; there is no
// back-pressure, so a strobe that finds the FSM in the wrong state is
// simply ignored.
module kplic_gateway_cell
    import kplic_gateway_pkg::*;
#(
    parameter int EDGE_CNT_W = KPLIC_EDGE_CNT_W
) (
    input  logic      kplic_clk,
    input  logic      kplic_rst,
    input  logic      src_i,
    input  logic      type_i,
    input  logic      enable_i,
    input  logic      claim_i,
    input  logic      completion_i,
    output gw_state_e state_o
);

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

    logic                  s;
    logic                  s_d_q;
    logic                  rise;
    logic                  req;
    logic                  queue_ok;
    gw_state_e             state_q, state_d;
    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;

`ifdef KPLIC_GW_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer: src_i may be asynchronous to kplic_clk.
    always_ff @(posedge kplic_clk) begin
        if (kplic_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    // Without the synchronizer src_i must already be synchronous.
    assign s = src_i;
`endif

    // One-cycle delayed sample for edge detection; reset to 0 so a line
    // that is already high at reset release is seen as a rise.
    always_ff @(posedge kplic_clk) begin
        if (kplic_rst) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign rise     = s & ~s_d_q;
    assign req      = enable_i & (type_i ? rise : s);
    assign queue_ok = type_i & enable_i;

    // State and queued-edge counter registers.
    always_ff @(posedge kplic_clk) begin
        if (kplic_rst) begin
            state_q <= GW_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a fresh request wins over draining the edge queue in
    // IDLE, so a new edge and a queued edge are never merged into one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            GW_IDLE: begin
                if (req) begin
                    state_d = GW_PENDING;
                end else if (queue_ok && (cnt_q != '0)) begin
                    state_d = GW_PENDING;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            GW_PENDING: begin
                if (claim_i) begin
                    state_d = GW_IN_SERVICE;
                end
                if (queue_ok && rise && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GW_IN_SERVICE: begin
                if (completion_i) begin
                    state_d = GW_IDLE;
                end
                if (queue_ok && rise && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = GW_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Level sources never queue edges.
        if (!type_i) begin
            cnt_d = '0;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/kplic_gateway.sv
// kplic_gateway: per-source interrupt gateway array of the KPLIC. Decodes
// the claimed ID into a one-hot claim vector and instantiates one
// kplic_gateway_cell per source; pending/in-service are decoded from the
// registered cell states.
// Build option: KPLIC_GW_SYNC_EN enables the per-source input synchronizer.
module kplic_gateway
    import kplic_gateway_pkg::*;
#(
    parameter int INT_NUM    = KPLIC_INT_NUM,
    parameter int INT_WIDTH  = KPLIC_INT_WIDTH,
    parameter int EDGE_CNT_W = KPLIC_EDGE_CNT_W
) (
    input  logic                 kplic_clk,
    input  logic                 kplic_rst,
    input  logic [INT_NUM-1:0]   int_src,
    input  logic [INT_NUM-1:0]   int_type,
    input  logic [INT_NUM-1:0]   int_enable,
    input  logic                 int_claim,
    input  logic [INT_WIDTH-1:0] claim_id,
    input  logic [INT_NUM-1:0]   int_completion,
    output logic [INT_NUM-1:0]   int_pending,
    output logic [INT_NUM-1:0]   int_in_service
);

    logic [INT_NUM-1:0] claim_vec;
    gw_state_e          cell_state [INT_NUM];

    // One-hot claim decode; IDs at or above INT_NUM match no source.
    always_comb begin
        claim_vec = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            claim_vec[i] = int_claim && (claim_id == INT_WIDTH'(i));
        end
    end

    for (genvar g = 0; g < INT_NUM; g++) begin : g_cell
        kplic_gateway_cell #(
            .EDGE_CNT_W (EDGE_CNT_W)
        ) u_cell (
            .kplic_clk    (kplic_clk),
            .kplic_rst    (kplic_rst),
            .src_i        (int_src[g]),
            .type_i       (int_type[g]),
            .enable_i     (int_enable[g]),
            .claim_i      (claim_vec[g]),
            .completion_i (int_completion[g]),
            .state_o      (cell_state[g])
        );

        assign int_pending[g]    = (cell_state[g] == GW_PENDING);
        assign int_in_service[g] = (cell_state[g] == GW_IN_SERVICE);
    end

endmodule

// File: tb/tb_kplic_gateway.sv
// tb_kplic_gateway: directed scenarios plus randomized traffic, every cycle
// compared against a per-source behavioural model of the gateway rules.
module tb_kplic_gateway;

    localparam int N       = 32;
    localparam int W       = 5;
    localparam int CNT_MAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  int_src = '0;
    logic [N-1:0]  int_type = '0;
    logic [N-1:0]  int_enable = '0;
    logic          int_claim = 1'b0;
    logic [W-1:0]  claim_id = '0;
    logic [N-1:0]  int_completion = '0;
    logic [N-1:0]  int_pending;
    logic [N-1:0]  int_in_service;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: per source a waiting flag, an in-service flag, a
    // count of remembered edges and the previous line sample.
    bit m_wait [N];
    bit m_busy [N];
    int m_edges[N];
    bit m_prev [N];

    kplic_gateway dut (
        .kplic_clk      (clk),
        .kplic_rst      (rst),
        .int_src        (int_src),
        .int_type       (int_type),
        .int_enable     (int_enable),
        .int_claim      (int_claim),
        .claim_id       (claim_id),
        .int_completion (int_completion),
        .int_pending    (int_pending),
        .int_in_service (int_in_service)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_pending();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_wait[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_service();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs the DUT samples.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit s, rise, req, edge_mode, live;
            if (rst) begin
                m_wait[i] = 0; m_busy[i] = 0; m_edges[i] = 0; m_prev[i] = 0;
                continue;
            end
            s         = int_src[i];
            rise      = s && !m_prev[i];
            edge_mode = int_type[i];
            live      = int_enable[i];
            req       = live && (edge_mode ? rise : s);
            if (!m_wait[i] && !m_busy[i]) begin
                if (req) m_wait[i] = 1;
                else if (edge_mode && live && m_edges[i] > 0) begin
                    m_wait[i] = 1;
                    m_edges[i] -= 1;
                end
            end else begin
                if (edge_mode && live && rise && m_edges[i] < CNT_MAX) m_edges[i] += 1;
                if (m_wait[i]) begin
                    if (int_claim && claim_id == i) begin m_wait[i] = 0; m_busy[i] = 1; end
                end else if (int_completion[i]) begin
                    m_busy[i] = 0;
                end
            end
            if (!edge_mode) m_edges[i] = 0;
            m_prev[i] = s;
        end
    endtask

    // One clock: model update on the edge, full comparison 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_vec("pending", int_pending, exp_pending());
        check_vec("in_service", int_in_service, exp_service());
    endtask

    task automatic quiet();
        int_claim = 1'b0; claim_id = '0; int_completion = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; int_src = '0; quiet();
        tick();
        check_vec("reset_pending", int_pending, '0);
        check_vec("reset_service", int_in_service, '0);
        rst = 1'b0;
    endtask

    task automatic claim(input int id);
        int_claim = 1'b1; claim_id = W'(id);
        tick();
        quiet();
    endtask

    task automatic complete(input int id);
        int_completion = '0; int_completion[id] = 1'b1;
        tick();
        quiet();
    endtask

    // Randomized traffic; claims/completions mostly target model-eligible
    // sources so the FSMs actually cycle.
    task automatic random_phase(input int cycles);
        int cand[$];
        for (int c = 0; c < cycles; c++) begin
            if (c % 150 == 0) begin
                int_type   = $urandom;
                int_enable = $urandom | $urandom;
            end
            if ($urandom_range(0, 9) == 0) int_enable ^= N'(1) << $urandom_range(0, N-1);
            int_src ^= $urandom & $urandom;
            quiet();
            if ($urandom_range(0, 1) == 1) begin
                cand.delete();
                for (int i = 0; i < N; i++) if (m_wait[i]) cand.push_back(i);
                int_claim = 1'b1;
                if (cand.size() > 0 && $urandom_range(0, 4) != 0)
                    claim_id = W'(cand[$urandom_range(0, cand.size()-1)]);
                else
                    claim_id = W'($urandom_range(0, N-1));
            end
            if ($urandom_range(0, 1) == 1) begin
                cand.delete();
                for (int i = 0; i < N; i++) if (m_busy[i]) cand.push_back(i);
                if (cand.size() > 0 && $urandom_range(0, 9) != 0)
                    int_completion[cand[$urandom_range(0, cand.size()-1)]] = 1'b1;
                else
                    int_completion[$urandom_range(0, N-1)] = 1'b1;
            end
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        quiet();
    endtask

    initial begin
        // Level source 3 held high.
        int_type = '0; int_enable = '1;
        do_reset();
        int_src[3] = 1'b1;
        tick();
        check_vec("lvl3_pend", N'(int_pending[3]), N'(1));
        claim(3);
        check_vec("lvl3_claim_pend", N'(int_pending[3]), N'(0));
        check_vec("lvl3_claim_svc", N'(int_in_service[3]), N'(1));
        complete(3);
        check_vec("lvl3_done_svc", N'(int_in_service[3]), N'(0));
        check_vec("lvl3_idle_gap", N'(int_pending[3]), N'(0));
        tick();
        check_vec("lvl3_repend", N'(int_pending[3]), N'(1));

        // Edge source 5: four edges while in service saturate the queue at 3.
        int_type = '0; int_type[5] = 1'b1;
        do_reset();
        int_src[5] = 1'b1; tick();
        int_src[5] = 1'b0;
        claim(5);
        for (int p = 0; p < 4; p++) begin
            int_src[5] = 1'b1; tick();
            int_src[5] = 1'b0; tick();
        end
        for (int r = 0; r < 3; r++) begin
            complete(5);
            check_vec("edge5_gap", N'(int_pending[5]), N'(0));
            tick();
            check_vec("edge5_repend", N'(int_pending[5]), N'(1));
            claim(5);
        end
        complete(5);
        tick(); tick();
        check_vec("edge5_drained", N'(int_pending[5] | int_in_service[5]), N'(0));

        // Disabled source 7 ignores toggles, then pends once enabled (level).
        int_type = '0; int_enable = '1; int_enable[7] = 1'b0;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            int_src[7] = ~int_src[7]; tick();
        end
        check_vec("dis7_pend", N'(int_pending[7]), N'(0));
        int_src[7] = 1'b1; int_enable[7] = 1'b1;
        tick();
        check_vec("en7_pend", N'(int_pending[7]), N'(1));

        // Source 9: claim while IDLE, completion while PENDING are ignored.
        int_type = '0; int_enable = '1;
        do_reset();
        claim(9);
        check_vec("s9_claim_idle", N'(int_pending[9] | int_in_service[9]), N'(0));
        int_src[9] = 1'b1; tick();
        int_src[9] = 1'b0;
        complete(9);
        check_vec("s9_cmpl_pend", N'(int_pending[9]), N'(1));
        check_vec("s9_cmpl_svc", N'(int_in_service[9]), N'(0));

        // Claim of 1 and completion of 2 in one cycle.
        do_reset();
        int_src[1] = 1'b1; int_src[2] = 1'b1; tick();
        int_src[2] = 1'b0;
        claim(2);
        int_claim = 1'b1; claim_id = W'(1); int_completion[2] = 1'b1;
        tick();
        quiet();
        check_vec("same_cyc_svc", int_in_service & 32'h6, 32'h2);
        check_vec("same_cyc_pend", int_pending & 32'h6, 32'h0);

        // Reset mid-service, then edge sources held high re-pend.
        int_type = '1; int_src = '1;
        tick();
        claim(4); claim(20);
        rst = 1'b1; tick();
        check_vec("rst_mid_pend", int_pending, '0);
        check_vec("rst_mid_svc", int_in_service, '0);
        rst = 1'b0; tick();
        check_vec("rst_release_pend", int_pending, '1);

        random_phase(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
